// File: rtl/display_pkg.sv
// Shared types and constants for the 7-segment display path: sequencer
// state encoding, divider widths, blank code and the saturation limit.
package display_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_GUARD = 3'd2,
        S_WAIT  = 3'd3,
        S_STORE = 3'd4,
        S_DONE  = 3'd5
    } seq_state_e;

    localparam logic [3:0] BCD_BLANK  = 4'hF;
    localparam int         DIV_WIDTH  = 14;
    localparam int         QUOT_WIDTH = 10;
    localparam int         MAX_VALUE  = 9999;

    // Saturate a request to the largest value the display can show.
    function automatic logic [DIV_WIDTH-1:0] clamp_value(
        input logic [DIV_WIDTH-1:0] v,
        input logic [DIV_WIDTH-1:0] lim
    );
        logic [DIV_WIDTH-1:0] r;
        if (v > lim) begin
            r = lim;
        end else begin
            r = v;
        end
        return r;
    endfunction

endpackage

// File: rtl/leading_zero_blank.sv
// Combinational leading-zero suppression: zero digits above the first
// non-zero digit become the blank code; digit0 is always shown.
module leading_zero_blank #(
    parameter int NUM_DIGITS = 4
) (
    input  logic [4*NUM_DIGITS-1:0] digits_i,
    output logic [4*NUM_DIGITS-1:0] digits_o
);
    import display_pkg::*;

    logic blanking_s;

    // Scan from the most significant digit down until a non-zero digit appears.
    always_comb begin
        digits_o   = digits_i;
        blanking_s = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            if (blanking_s && (digits_i[i*4 +: 4] == 4'd0)) begin
                digits_o[i*4 +: 4] = BCD_BLANK;
            end else begin
                blanking_s = 1'b0;
            end
        end
    end

endmodule

// File: rtl/bcd_digit_sequencer.sv
// Binary-to-BCD sequencer driving an external divide-by-10 unit; digits are
// produced LSD first. Define LEADING_ZERO_BLANK_EN to blank leading zeros.
module bcd_digit_sequencer #(
    parameter int NUM_DIGITS = 4,
    parameter int MAX_VALUE  = display_pkg::MAX_VALUE
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [display_pkg::DIV_WIDTH-1:0]   value,
    input  logic                                convert,
    output logic                                busy,
    output logic                                valid,
    output logic                                ovf,
    output logic [4*NUM_DIGITS-1:0]             digits,
    output logic                                div_start,
    output logic [display_pkg::DIV_WIDTH-1:0]   div_dividend,
    input  logic [display_pkg::QUOT_WIDTH-1:0]  div_quotient,
    input  logic [display_pkg::DIV_WIDTH-1:0]   div_remainder,
    input  logic                                div_done
);
    import display_pkg::*;

    localparam int                   IDX_W    = 2;
    localparam logic [DIV_WIDTH-1:0] MAX_C    = DIV_WIDTH'(MAX_VALUE);
    localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(NUM_DIGITS - 1);

    seq_state_e              state_q, state_d;
    logic [DIV_WIDTH-1:0]    work_q, work_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
    logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
    logic                    busy_q, busy_d;
    logic                    valid_q, valid_d;
    logic                    ovf_q, ovf_d;
    logic                    start_q, start_d;
    logic [4*NUM_DIGITS-1:0] disp_s;
    logic                    unused_rem_s;

    // Upper remainder bits are always zero for a divide-by-10.
    assign unused_rem_s = ^div_remainder[DIV_WIDTH-1:4];

`ifdef LEADING_ZERO_BLANK_EN
    leading_zero_blank #(
        .NUM_DIGITS (NUM_DIGITS)
    ) u_blank (
        .digits_i (shadow_q),
        .digits_o (disp_s)
    );
`else
    assign disp_s = shadow_q;
`endif

    // Next-state and datapath decode for the conversion sequence.
    always_comb begin
        state_d  = state_q;
        work_d   = work_q;
        idx_d    = idx_q;
        shadow_d = shadow_q;
        digits_d = digits_q;
        busy_d   = busy_q;
        valid_d  = 1'b0;
        ovf_d    = ovf_q;
        start_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (convert) begin
                    work_d   = clamp_value(value, MAX_C);
                    ovf_d    = (value > MAX_C);
                    busy_d   = 1'b1;
                    idx_d    = '0;
                    shadow_d = '0;
                    start_d  = 1'b1;
                    state_d  = S_LOAD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOAD: begin
                state_d = S_GUARD;
            end
            // A done left over from the previous division is still visible here.
            S_GUARD: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (div_done) begin
                    state_d = S_STORE;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_STORE: begin
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    if (idx_q == IDX_W'(i)) begin
                        shadow_d[i*4 +: 4] = div_remainder[3:0];
                    end else begin
                        shadow_d[i*4 +: 4] = shadow_q[i*4 +: 4];
                    end
                end
                work_d = {4'b0000, div_quotient};
                if (idx_q == LAST_IDX) begin
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                    start_d = 1'b1;
                    state_d = S_LOAD;
                end
            end
            S_DONE: begin
                digits_d = disp_s;
                valid_d  = 1'b1;
                busy_d   = 1'b0;
                state_d  = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset aborts any conversion in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            work_q   <= '0;
            idx_q    <= '0;
            shadow_q <= '0;
            digits_q <= '0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
            ovf_q    <= 1'b0;
            start_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            work_q   <= work_d;
            idx_q    <= idx_d;
            shadow_q <= shadow_d;
            digits_q <= digits_d;
            busy_q   <= busy_d;
            valid_q  <= valid_d;
            ovf_q    <= ovf_d;
            start_q  <= start_d;
        end
    end

    assign busy         = busy_q;
    assign valid        = valid_q;
    assign ovf          = ovf_q;
    assign digits       = digits_q;
    assign div_start    = start_q;
    assign div_dividend = work_q;

endmodule

// File: tb/tb_bcd_digit_sequencer.sv
// Directed self-checking bench for bcd_digit_sequencer with a behavioural
// divide10 (fixed latency, done held until the next start).
module tb_bcd_digit_sequencer;

    localparam int LD      = 3;
    localparam int LATENCY = 4 * (3 + LD) + 2;

    logic        clk;
    logic        rst_n;
    logic [13:0] value;
    logic        convert;
    logic        busy;
    logic        valid;
    logic        ovf;
    logic [15:0] digits;
    logic        div_start;
    logic [13:0] div_dividend;
    logic [9:0]  div_quotient;
    logic [13:0] div_remainder;
    logic        div_done;

    int n_checks;
    int n_errors;
    int valid_cnt;

    logic        m_busy;
    int          m_cnt;
    logic [13:0] m_div;

    bcd_digit_sequencer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .value         (value),
        .convert       (convert),
        .busy          (busy),
        .valid         (valid),
        .ovf           (ovf),
        .digits        (digits),
        .div_start     (div_start),
        .div_dividend  (div_dividend),
        .div_quotient  (div_quotient),
        .div_remainder (div_remainder),
        .div_done      (div_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural divide10: result LD cycles after start, done kept until cleared.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy        <= 1'b0;
            m_cnt         <= 0;
            m_div         <= 14'd0;
            div_done      <= 1'b0;
            div_quotient  <= 10'd0;
            div_remainder <= 14'd0;
        end else if (div_start) begin
            m_busy <= 1'b1;
            m_cnt  <= LD - 1;
            m_div  <= div_dividend;
        end else if (m_busy) begin
            if (m_cnt == 0) begin
                div_done      <= 1'b1;
                div_quotient  <= 10'(m_div / 14'd10);
                div_remainder <= 14'(m_div % 14'd10);
                m_busy        <= 1'b0;
            end else begin
                m_cnt    <= m_cnt - 1;
                div_done <= 1'b0;
            end
        end
    end

    // Count valid strobes, sampled mid-cycle.
    always @(negedge clk) begin
        if (valid) valid_cnt <= valid_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] fmt(input logic [15:0] raw);
        logic [15:0] r;
        r = raw;
`ifdef LEADING_ZERO_BLANK_EN
        for (int i = 3; i >= 1; i--) begin
            if (r[i*4 +: 4] == 4'd0) r[i*4 +: 4] = 4'hF;
            else break;
        end
`endif
        return r;
    endfunction

    // Wait for valid at negedges; returns the number of negedges waited.
    task automatic wait_valid(input string tag, output int n);
        bit got;
        got = 1'b0;
        n   = 0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            n++;
            if (valid) got = 1'b1;
        end
        if (!got) check({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic run_one(input string tag, input logic [13:0] v,
                           input logic [15:0] exp_raw, input logic exp_ovf);
        int n;
        @(negedge clk);
        value   = v;
        convert = 1'b1;
        @(negedge clk);
        convert = 1'b0;
        if (valid) n = 1;
        else begin
            wait_valid(tag, n);
            n = n + 1;
        end
        check({tag, "_latency"}, 32'(n), 32'(LATENCY));
        check({tag, "_digits"}, {16'd0, digits}, {16'd0, fmt(exp_raw)});
        check({tag, "_ovf"}, {31'd0, ovf}, {31'd0, exp_ovf});
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        @(negedge clk);
        check({tag, "_pulse"}, {31'd0, valid}, 32'd0);
    endtask

    initial begin
        int n;
        int snap;
        n_checks  = 0;
        n_errors  = 0;
        valid_cnt = 0;
        rst_n     = 1'b0;
        value     = 14'd0;
        convert   = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy",   {31'd0, busy}, 32'd0);
        check("rst_valid",  {31'd0, valid}, 32'd0);
        check("rst_ovf",    {31'd0, ovf}, 32'd0);
        check("rst_digits", {16'd0, digits}, 32'd0);
        check("rst_start",  {31'd0, div_start}, 32'd0);
        check("rst_divd",   {18'd0, div_dividend}, 32'd0);
        rst_n = 1'b1;

        run_one("v34",    14'd34,    16'h0034, 1'b0);
        run_one("v9999",  14'd9999,  16'h9999, 1'b0);
        run_one("v10",    14'd10,    16'h0010, 1'b0);
        run_one("v12000", 14'd12000, 16'h9999, 1'b1);
        run_one("v5",     14'd5,     16'h0005, 1'b0);
        run_one("v0",     14'd0,     16'h0000, 1'b0);

        // convert held high; value changes while busy must be ignored
        @(negedge clk);
        value   = 14'd123;
        convert = 1'b1;
        @(negedge clk);
        value = 14'd4567;
        wait_valid("cont1", n);
        check("cont1_digits", {16'd0, digits}, {16'd0, fmt(16'h0123)});
        @(negedge clk);
        value = 14'd8;
        if (valid) n = 0;
        else begin
            wait_valid("cont2", n);
        end
        check("cont_sep", 32'(n + 1), 32'(LATENCY));
        check("cont2_digits", {16'd0, digits}, {16'd0, fmt(16'h4567)});
        check("cont2_ovf", {31'd0, ovf}, 32'd0);
        convert = 1'b0;
        snap = valid_cnt;
        repeat (40) @(negedge clk);
        check("cont_drain", 32'(valid_cnt), 32'(snap + 1));

        // reset asserted while waiting on the third division
        @(negedge clk);
        value   = 14'd1234;
        convert = 1'b1;
        @(negedge clk);
        convert = 1'b0;
        repeat (15) @(negedge clk);
        check("mid_busy_before", {31'd0, busy}, 32'd1);
        check("mid_divd_before", {18'd0, div_dividend}, 32'd12);
        snap  = valid_cnt;
        rst_n = 1'b0;
        #1;
        check("mid_busy",   {31'd0, busy}, 32'd0);
        check("mid_valid",  {31'd0, valid}, 32'd0);
        check("mid_ovf",    {31'd0, ovf}, 32'd0);
        check("mid_digits", {16'd0, digits}, 32'd0);
        check("mid_start",  {31'd0, div_start}, 32'd0);
        check("mid_divd",   {18'd0, div_dividend}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        check("mid_no_valid", 32'(valid_cnt), 32'(snap));
        check("mid_idle_digits", {16'd0, digits}, 32'd0);

        run_one("v1234", 14'd1234, 16'h1234, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/bcd_digit_sequencer.md
Name: bcd_digit_sequencer

Overview:
- Upstream control stage for divide10: converts a 14-bit binary value (0..9999) into four packed BCD digits for the 7-segment display path.
- Issues repeated divide-by-10 operations: each remainder is one digit (LSD first), and each quotient becomes the next dividend.
- Owns divide10's start/dividend inputs and consumes its quotient/remainder/done outputs.
- Presents the finished digits to the display multiplexer with a one-cycle valid strobe.

Parameters:
- NUM_DIGITS, 4, digits produced; fixed at 4 for the 14-bit divider, legal range 1..4.
- MAX_VALUE, 9999, saturation limit; must equal 10**NUM_DIGITS-1.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  asynchronous active-low reset
- value  input  14  binary value to convert, sampled on convert
- convert  input  1  request pulse; accepted only in IDLE
- busy  output  1  high from accept until valid
- valid  output  1  one-cycle strobe when digits update
- ovf  output  1  value exceeded MAX_VALUE on last accepted request
- digits  output  4*NUM_DIGITS  packed BCD, digit0 in [3:0]
- div_start  output  1  start pulse to divide10
- div_dividend  output  14  dividend to divide10
- div_quotient  input  10  quotient from divide10
- div_remainder  input  14  remainder from divide10
- div_done  input  1  divide10 completion flag (may remain high until next start)

Behaviour:
- Reset (async, rst_n low):
  - State goes to IDLE.
  - busy=0, valid=0, ovf=0, digits=0, div_start=0, div_dividend=0, digit index=0.
- State IDLE:
  - convert=1 latches value into the working register.
  - If value>MAX_VALUE, latch MAX_VALUE and set ovf=1; otherwise clear ovf.
  - busy=1, index=0, go to LOAD.
- State LOAD (1 cycle):
  - div_start=1, div_dividend=working register, go to GUARD.
- State GUARD (1 cycle):
  - div_start=0 and div_done is ignored, so a stale done from the prior operation is never accepted; go to WAIT.
- State WAIT:
  - Hold until div_done=1, then go to STORE.
  - No timeout.
- State STORE (1 cycle):
  - Shadow digit[index] = div_remainder[3:0]. Remainder bits [13:4] are always 0; not checked in RTL.
  - Working register = {4'b0, div_quotient}.
  - If index==NUM_DIGITS-1, go to DONE; otherwise index+1 and go to LOAD.
- State DONE (1 cycle):
  - digits = shadow, valid=1, busy=0, go to IDLE.
- Output timing:
  - Digits are held stable between valid strobes; the shadow register keeps the display glitch-free during conversion.
  - Latency from convert to valid = NUM_DIGITS*(3+Ld)+2 cycles, where Ld = divider cycles from start to done.
- Boundary conditions:
  - convert while busy: ignored, never queued.
  - convert asserted in the DONE cycle: ignored; it is accepted on the next cycle if still high.
  - value=0: all digits 0, still runs the full NUM_DIGITS divisions.
  - Reset mid-conversion: immediate abort; digits return to 0 and no valid is issued.

Optional Feature:
- LEADING_ZERO_BLANK_EN defined:
  - In DONE, leading zero digits are replaced by 4'hF (blank code for the segment decoder), scanning from the MSD down.
  - digit0 is never blanked.
  - Example: 34 yields 16'hFF34.
- Undefined: raw BCD with leading zeros.

Decomposition:
- Shared package display_pkg:
  - State enum (IDLE, LOAD, GUARD, WAIT, STORE, DONE).
  - BCD_BLANK=4'hF, DIV_WIDTH=14, QUOT_WIDTH=10, MAX_VALUE constant.
- Optional sub-module: leading_zero_blank, combinational and instantiated only under LEADING_ZERO_BLANK_EN.
- The FSM and datapath stay in one module.

Test Plan:
- convert with value=34 (real divide10 in bench) -> one valid pulse, digits=16'h0034, ovf=0, busy low on the valid cycle.
- value=9999 -> digits=16'h9999, ovf=0; value=10 -> 16'h0010.
- value=12000 -> digits=16'h9999, ovf=1; following convert with value=5 -> 16'h0005, ovf=0.
- value=0, macro defined -> 16'hFFF0; macro undefined -> 16'h0000.
- convert=1 held continuously with value changing mid-conversion -> each result matches the value sampled at acceptance; valid pulses separated by exactly NUM_DIGITS*(3+Ld)+2 cycles.
- rst_n low during WAIT of digit 2 -> all outputs 0 asynchronously, no valid; a fresh convert with 1234 -> 16'h1234.
